// File: rtl/bpu_pkg.sv
// Shared definitions for the local branch prediction unit.
//   - bpu_state_e : init sweep / normal operation state encoding
//   - clog2       : ceiling log2, never below 1 so derived widths stay legal
//   - ctr_init    : weakly not-taken starting value of a CTR_W-bit counter
//   - ctr_sat_step: one saturating increment/decrement of a counter
package bpu_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bpu_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // 2^(ctr_w-1)-1: the highest value whose MSB is still 0.
    function automatic int unsigned ctr_init(input int ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned ctr_sat_step(input int unsigned ctr,
                                                 input logic        up,
                                                 input int          ctr_w);
        int unsigned max_v;
        max_v = (32'd1 << ctr_w) - 32'd1;
        if (up) begin
            return (ctr == max_v) ? ctr : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bpu_init_seq.sv
// Post-reset table sweep sequencer.
//   clk, rst     : clock, asynchronous active-high reset
//   init_busy_o  : high while the sweep is in progress (INIT state)
//   init_idx_o   : table index being cleared this cycle
//   ready_o      : high once the sweep has finished (RUN state)
//   state_o      : current FSM state, for observation
// The sweep visits indices 0..DEPTH-1, one per cycle, then stays in RUN
// until the next reset.
module bpu_init_seq
    import bpu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_busy_o,
    output logic [CNT_W-1:0] init_idx_o,
    output logic             ready_o,
    output bpu_state_e       state_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    bpu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign init_busy_o = (state_q == ST_INIT);
    assign init_idx_o  = cnt_q;
    assign ready_o     = (state_q == ST_RUN);
    assign state_o     = state_q;

endmodule

// File: rtl/bpu_local_btb.sv
// Branch prediction unit: direct-mapped tagged BTB plus a PAg local
// predictor (per-branch history table indexing a shared counter table).
//   clk, rst            : clock, asynchronous active-high reset
//   ready_o             : tables initialised, unit accepting traffic
//   lookup_*_i          : one lookup per cycle from the PC controller
//   pred_*_o            : registered prediction, one cycle after lookup
//   upd_*_i             : one resolved-branch update per cycle from execute
// Handshake: lookup_valid_i and upd_valid_i are single-cycle strobes with
// no back-pressure; both are ignored while ready_o is low. pred_valid_o
// pulses for exactly one cycle per accepted lookup; the other pred_*_o
// outputs hold their last value between predictions.
// A lookup and an update in the same cycle: the lookup sees the tables as
// they were before that update.
module bpu_local_btb
    import bpu_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int LHT_ENTRIES = 32,
    parameter int HIST_W      = 4,
    parameter int CTR_W       = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready_o,
    input  logic            lookup_valid_i,
    input  logic [PC_W-1:0] lookup_pc_i,
    input  logic            lookup_is_cond_i,
    output logic            pred_valid_o,
    output logic            pred_hit_o,
    output logic            pred_taken_o,
    output logic [PC_W-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic            upd_is_cond_i,
    input  logic            upd_taken_i,
    input  logic [PC_W-1:0] upd_target_i
);

    localparam int IDX_W       = clog2(BTB_ENTRIES);
    localparam int TAG_W       = PC_W - IDX_W;
    localparam int LIDX_W      = clog2(LHT_ENTRIES);
    localparam int PHT_ENTRIES = 1 << HIST_W;
    localparam int SWEEP_AB    = (BTB_ENTRIES > LHT_ENTRIES) ? BTB_ENTRIES : LHT_ENTRIES;
    localparam int SWEEP_LEN   = (SWEEP_AB > PHT_ENTRIES) ? SWEEP_AB : PHT_ENTRIES;
    localparam int CNT_W       = clog2(SWEEP_LEN);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

    // Tables carry no reset; the init sweep clears them.
    logic              btb_valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q   [BTB_ENTRIES];
    logic [PC_W-1:0]   btb_tgt_q   [BTB_ENTRIES];
    logic [HIST_W-1:0] lht_q       [LHT_ENTRIES];
    logic [CTR_W-1:0]  pht_q       [PHT_ENTRIES];

    logic             pred_valid_q, pred_hit_q, pred_taken_q;
    logic [PC_W-1:0]  pred_target_q;

    logic             init_busy;
    logic [CNT_W-1:0] init_idx;
    bpu_state_e       init_state;
    logic             run;

    bpu_init_seq #(
        .DEPTH (SWEEP_LEN),
        .CNT_W (CNT_W)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .init_busy_o (init_busy),
        .init_idx_o  (init_idx),
        .ready_o     (ready_o),
        .state_o     (init_state)
    );

    assign run = (init_state == ST_RUN);

    // Lookup path (reads current table contents, i.e. pre-update).
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [LIDX_W-1:0] lk_lidx;
    logic [HIST_W-1:0] lk_hist;
    logic              lk_hit, lk_taken;
    logic [PC_W-1:0]   lk_target;

    assign lk_idx    = lookup_pc_i[IDX_W-1:0];
    assign lk_tag    = lookup_pc_i[PC_W-1:IDX_W];
    assign lk_lidx   = lookup_pc_i[LIDX_W-1:0];
    assign lk_hist   = lht_q[lk_lidx];
    assign lk_hit    = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign lk_target = lk_hit ? btb_tgt_q[lk_idx] : '0;
    // Unconditional jumps that hit are always taken; conditionals follow
    // the counter MSB.
    assign lk_taken  = lk_hit && (lookup_is_cond_i ? pht_q[lk_hist][CTR_W-1] : 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q <= run && lookup_valid_i;
            if (run && lookup_valid_i) begin
                pred_hit_q    <= lk_hit;
                pred_taken_q  <= lk_taken;
                pred_target_q <= lk_target;
            end
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_hit_o    = pred_hit_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_target_o = pred_target_q;

    // Update path.
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic [LIDX_W-1:0] upd_lidx;
    logic [HIST_W-1:0] upd_hist;
    logic [CTR_W-1:0]  upd_ctr_cur, upd_ctr_nxt;

    assign upd_idx     = upd_pc_i[IDX_W-1:0];
    assign upd_tag     = upd_pc_i[PC_W-1:IDX_W];
    assign upd_lidx    = upd_pc_i[LIDX_W-1:0];
    assign upd_hist    = lht_q[upd_lidx];
    assign upd_ctr_cur = pht_q[upd_hist];
    assign upd_ctr_nxt = CTR_W'(ctr_sat_step(32'(upd_ctr_cur), upd_taken_i, CTR_W));

    always_ff @(posedge clk) begin
        if (init_busy) begin
            if (int'(init_idx) < BTB_ENTRIES) begin
                btb_valid_q[init_idx[IDX_W-1:0]] <= 1'b0;
            end
            if (int'(init_idx) < LHT_ENTRIES) begin
                lht_q[init_idx[LIDX_W-1:0]] <= '0;
            end
            if (int'(init_idx) < PHT_ENTRIES) begin
                pht_q[init_idx[HIST_W-1:0]] <= CTR_INIT;
            end
        end else if (run && upd_valid_i) begin
            // Not-taken branches never allocate; a taken one overwrites
            // whatever alias occupies the slot.
            if (upd_taken_i) begin
                btb_valid_q[upd_idx] <= 1'b1;
                btb_tag_q[upd_idx]   <= upd_tag;
                btb_tgt_q[upd_idx]   <= upd_target_i;
            end
            if (upd_is_cond_i) begin
                pht_q[upd_hist] <= upd_ctr_nxt;
                lht_q[upd_lidx] <= {upd_hist[HIST_W-2:0], upd_taken_i};
            end
        end
    end

endmodule

// File: tb/tb_bpu_local_btb.sv
// Self-checking bench for bpu_local_btb: directed scenarios followed by
// random traffic, all predictions compared against a table-level model.
module tb_bpu_local_btb;

    localparam int PC_W  = 32;
    localparam int BTB_N = 64;
    localparam int LHT_N = 32;
    localparam int PHT_N = 16;
    localparam int CTR_MAX = 3;
    localparam int SWEEP = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            ready;
    logic            lookup_valid;
    logic [PC_W-1:0] lookup_pc;
    logic            lookup_is_cond;
    logic            pred_valid, pred_hit, pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_is_cond, upd_taken;
    logic [PC_W-1:0] upd_target;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    bpu_local_btb dut (
        .clk              (clk),
        .rst              (rst),
        .ready_o          (ready),
        .lookup_valid_i   (lookup_valid),
        .lookup_pc_i      (lookup_pc),
        .lookup_is_cond_i (lookup_is_cond),
        .pred_valid_o     (pred_valid),
        .pred_hit_o       (pred_hit),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_is_cond_i    (upd_is_cond),
        .upd_taken_i      (upd_taken),
        .upd_target_i     (upd_target)
    );

    // ---------------- reference model ----------------
    bit          m_btb_v   [BTB_N];
    int unsigned m_btb_tag [BTB_N];
    int unsigned m_btb_tgt [BTB_N];
    int          m_lht     [LHT_N];
    int          m_pht     [PHT_N];
    bit          model_run;
    bit          last_hit, last_taken;
    int unsigned last_tgt;

    // expected {valid, hit, taken, target}
    logic [PC_W+2:0] exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < BTB_N; i++) m_btb_v[i] = 1'b0;
        for (int i = 0; i < LHT_N; i++) m_lht[i] = 0;
        for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
        model_run  = 1'b0;
        last_hit   = 1'b0;
        last_taken = 1'b0;
        last_tgt   = 0;
    endfunction

    function automatic void model_lookup(input int unsigned pc, input bit cond,
                                         output bit hit, output bit taken,
                                         output int unsigned tgt);
        int unsigned idx;
        idx   = pc % BTB_N;
        hit   = m_btb_v[idx] && (m_btb_tag[idx] == pc / BTB_N);
        tgt   = hit ? m_btb_tgt[idx] : 0;
        taken = hit && (!cond || m_pht[m_lht[pc % LHT_N]] >= 2);
    endfunction

    function automatic void model_update(input int unsigned pc, input bit cond,
                                         input bit tk, input int unsigned tgt);
        int unsigned idx;
        int h;
        idx = pc % BTB_N;
        if (tk) begin
            m_btb_v[idx]   = 1'b1;
            m_btb_tag[idx] = pc / BTB_N;
            m_btb_tgt[idx] = tgt;
        end
        if (cond) begin
            h = m_lht[pc % LHT_N];
            if (tk) m_pht[h] = (m_pht[h] < CTR_MAX) ? m_pht[h] + 1 : CTR_MAX;
            else    m_pht[h] = (m_pht[h] > 0) ? m_pht[h] - 1 : 0;
            m_lht[pc % LHT_N] = (h * 2 + int'(tk)) % PHT_N;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; drives one cycle of traffic, then
    // checks the prediction outputs after the next rising edge.
    task automatic do_cycle(input logic lv, input logic [PC_W-1:0] lpc, input logic lc,
                            input logic uv, input logic [PC_W-1:0] upc, input logic uc,
                            input logic ut, input logic [PC_W-1:0] utgt);
        bit              h, t;
        int unsigned     g;
        logic [PC_W+2:0] e;
        lookup_valid   = lv;
        lookup_pc      = lpc;
        lookup_is_cond = lc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_is_cond    = uc;
        upd_taken      = ut;
        upd_target     = utgt;
        if (model_run && lv) begin
            model_lookup(lpc, lc, h, t, g);
            last_hit   = h;
            last_taken = t;
            last_tgt   = g;
            e = {1'b1, last_hit, last_taken, last_tgt};
        end else begin
            e = {1'b0, last_hit, last_taken, last_tgt};
        end
        exp_q.push_back(e);
        if (model_run && uv) model_update(upc, uc, ut, utgt);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("pred_valid",  64'(pred_valid),  64'(e[PC_W+2]));
        check_eq("pred_hit",    64'(pred_hit),    64'(e[PC_W+1]));
        check_eq("pred_taken",  64'(pred_taken),  64'(e[PC_W]));
        check_eq("pred_target", 64'(pred_target), 64'(e[PC_W-1:0]));
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc, input logic cond);
        do_cycle(1'b1, pc, cond, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic update(input logic [PC_W-1:0] pc, input logic cond, input logic tk,
                          input logic [PC_W-1:0] tgt);
        do_cycle(1'b0, '0, 1'b0, 1'b1, pc, cond, tk, tgt);
    endtask

    function automatic logic [PC_W-1:0] rand_pc();
        return PC_W'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7) | ($urandom_range(0, 1) << 4));
    endfunction

    // Sweep phase right after reset release: random traffic must be
    // ignored and ready must stay low for exactly SWEEP cycles.
    task automatic init_phase();
        check_eq("ready_init_first", 64'(ready), 64'd0);
        for (int i = 0; i < SWEEP; i++) begin
            do_cycle(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)),
                     1'b1, $urandom);
            check_eq("ready_sweep", 64'(ready), (i == SWEEP - 1) ? 64'd1 : 64'd0);
        end
        model_run = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        lookup_valid = 1'b0; lookup_pc = '0; lookup_is_cond = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_is_cond = 1'b0; upd_taken = 1'b0; upd_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready",  64'(ready),       64'd0);
        check_eq("rst_valid",  64'(pred_valid),  64'd0);
        check_eq("rst_hit",    64'(pred_hit),    64'd0);
        check_eq("rst_taken",  64'(pred_taken),  64'd0);
        check_eq("rst_target", 64'(pred_target), 64'd0);
        rst = 1'b0;
        init_phase();

        // cold lookup
        lookup(32'h10, 1'b1);

        // train 0x10 taken five times, then predict
        repeat (5) update(32'h10, 1'b1, 1'b1, 32'h80);
        lookup(32'h10, 1'b1);
        update(32'h10, 1'b1, 1'b0, 32'h80);
        lookup(32'h10, 1'b1);

        // unconditional jump
        update(32'h20, 1'b0, 1'b1, 32'h40);
        lookup(32'h20, 1'b0);
        lookup(32'h00, 1'b1);

        // aliasing and read-before-write
        lookup(32'h50, 1'b1);
        do_cycle(1'b1, 32'h50, 1'b1, 1'b1, 32'h50, 1'b0, 1'b1, 32'h99);
        lookup(32'h50, 1'b1);
        lookup(32'h10, 1'b1);

        // saturation: prime another branch to history 1111, saturate the
        // shared 1111 counter, back it off once, then predict through it
        repeat (4) update(32'h11, 1'b1, 1'b1, 32'h123);
        repeat (8) update(32'h10, 1'b1, 1'b1, 32'h80);
        update(32'h10, 1'b1, 1'b0, 32'h80);
        lookup(32'h11, 1'b1);
        lookup(32'h10, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 3) != 0), rand_pc(), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 2) != 0), $urandom);
        end

        // reset mid-stream after a hitting prediction
        update(32'h11, 1'b0, 1'b1, 32'h321);
        lookup(32'h11, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ready",  64'(ready),       64'd0);
        check_eq("mid_rst_valid",  64'(pred_valid),  64'd0);
        check_eq("mid_rst_hit",    64'(pred_hit),    64'd0);
        check_eq("mid_rst_taken",  64'(pred_taken),  64'd0);
        check_eq("mid_rst_target", 64'(pred_target), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        init_phase();
        lookup(32'h10, 1'b1);
        lookup(32'h11, 1'b0);
        do_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
